// File: rtl/mem_bus_arbiter.sv
// Shares one single-port RAM between the cpu (fixed timing, always wins) and port B (cycle stealing).
// Define MEM_ARB_MMIO_EN to add the led_out/sw_in I/O registers in the addr[8]=1 space.
module mem_bus_arbiter #(
   parameter int RAM_AW       = 8,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        cpu_mem_cmd,
   input  logic [RAM_AW:0]   cpu_mem_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [RAM_AW:0]   b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_busy,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              starve,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
`ifdef MEM_ARB_MMIO_EN
   ,
   output logic [7:0]        led_out,
   input  logic [7:0]        sw_in
`endif
);

   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PEND,
      ST_RDWAIT,
      ST_ACK
   } state_t;

   state_t            state_q, state_d;
   logic              hold_we_q, hold_we_d;
   logic [RAM_AW:0]   hold_addr_q, hold_addr_d;
   logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
   logic [RAM_AW-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_q;

   logic              cpu_act;
   logic              cpu_wr;
   logic              b_grant;
   logic [DATA_W-1:0] cpu_io_rdata;
   logic [DATA_W-1:0] b_io_rdata;

   assign cpu_act = (cpu_mem_cmd == CMD_READ) || (cpu_mem_cmd == CMD_WRITE);
   assign cpu_wr  = (cpu_mem_cmd == CMD_WRITE);
   // Port B only reaches the RAM in a PEND cycle the cpu leaves idle.
   assign b_grant = (state_q == ST_PEND) && !cpu_act;

`ifdef MEM_ARB_MMIO_EN
   localparam logic [RAM_AW:0] LED_ADDR = (RAM_AW+1)'(9'h100);
   localparam logic [RAM_AW:0] SW_ADDR  = (RAM_AW+1)'(9'h140);

   logic [7:0] led_q, led_d;

   function automatic logic [DATA_W-1:0] io_read(input logic [RAM_AW:0] addr,
                                                 input logic [7:0]   sw);
      return (addr == SW_ADDR) ? {{(DATA_W-8){1'b0}}, sw} : '0;
   endfunction

   assign cpu_io_rdata = io_read(cpu_mem_addr, sw_in);
   assign b_io_rdata   = io_read(hold_addr_q, sw_in);
   assign led_out      = led_q;

   always_comb begin
      led_d = led_q;
      if (cpu_wr && (cpu_mem_addr == LED_ADDR)) begin
         led_d = cpu_wdata[7:0];
      end else if (b_grant && hold_we_q && (hold_addr_q == LED_ADDR)) begin
         led_d = hold_wdata_q[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q <= 8'h00;
      end else begin
         led_q <= led_d;
      end
   end
`else
   assign cpu_io_rdata = '0;
   assign b_io_rdata   = '0;
`endif

   assign cpu_rdata = cpu_mem_addr[RAM_AW] ? cpu_io_rdata : ram_rdata;

   // RAM port mux; an idle bus keeps presenting the last driven address/data.
   always_comb begin
      ram_addr  = ram_addr_q;
      ram_wdata = ram_wdata_q;
      ram_we    = 1'b0;
      if (cpu_act) begin
         ram_addr  = cpu_mem_addr[RAM_AW-1:0];
         ram_wdata = cpu_wdata;
         ram_we    = cpu_wr && !cpu_mem_addr[RAM_AW];
      end else if (b_grant) begin
         ram_addr  = hold_addr_q[RAM_AW-1:0];
         ram_wdata = hold_wdata_q;
         ram_we    = hold_we_q && !hold_addr_q[RAM_AW];
      end
   end

   always_comb begin
      state_d      = state_q;
      hold_we_d    = hold_we_q;
      hold_addr_d  = hold_addr_q;
      hold_wdata_d = hold_wdata_q;
      cnt_d        = cnt_q;
      b_rdata_d    = b_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (b_req) begin
               hold_we_d    = b_we;
               hold_addr_d  = b_addr;
               hold_wdata_d = b_wdata;
               state_d      = ST_PEND;
            end
         end
         ST_PEND: begin
            if (!cpu_act) begin
               state_d = hold_we_q ? ST_ACK : ST_RDWAIT;
            end else if (cnt_q != 4'hF) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RDWAIT: begin
            // RAM data here answers the address driven in the granted PEND cycle.
            b_rdata_d = hold_addr_q[RAM_AW] ? b_io_rdata : ram_rdata;
            state_d   = ST_ACK;
         end
         ST_ACK: begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         hold_we_q    <= 1'b0;
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
         cnt_q        <= 4'd0;
         b_rdata_q    <= '0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         hold_we_q    <= hold_we_d;
         hold_addr_q  <= hold_addr_d;
         hold_wdata_q <= hold_wdata_d;
         cnt_q        <= cnt_d;
         b_rdata_q    <= b_rdata_d;
         ram_addr_q   <= ram_addr;
         ram_wdata_q  <= ram_wdata;
      end
   end

   assign b_busy  = (state_q == ST_PEND) || (state_q == ST_RDWAIT);
   assign b_ack   = (state_q == ST_ACK);
   assign b_rdata = b_rdata_q;
   assign starve  = (cnt_q == 4'(STARVE_LIMIT));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a synchronous RAM model; MMIO checks follow MEM_ARB_MMIO_EN.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  cpu_mem_cmd;
   logic [8:0]  cpu_mem_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        b_req;
   logic        b_we;
   logic [8:0]  b_addr;
   logic [15:0] b_wdata;
   logic        b_busy;
   logic        b_ack;
   logic [15:0] b_rdata;
   logic        starve;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
`ifdef MEM_ARB_MMIO_EN
   logic [7:0]  led_out;
   logic [7:0]  sw_in;
   localparam logic [15:0] SW_RD = 16'h003C;
`else
   localparam logic [15:0] SW_RD = 16'h0000;
`endif

   int errors = 0;
   int checks = 0;

   mem_bus_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_mem_cmd  (cpu_mem_cmd),
      .cpu_mem_addr (cpu_mem_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .b_req        (b_req),
      .b_we         (b_we),
      .b_addr       (b_addr),
      .b_wdata      (b_wdata),
      .b_busy       (b_busy),
      .b_ack        (b_ack),
      .b_rdata      (b_rdata),
      .starve       (starve),
      .ram_addr     (ram_addr),
      .ram_we       (ram_we),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata)
`ifdef MEM_ARB_MMIO_EN
      ,
      .led_out      (led_out),
      .sw_in        (sw_in)
`endif
   );

   // Synchronous single-port RAM, read-before-write.
   logic        mem_clr;
   logic [15:0] mem [0:255];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   int bad;
   int acks;

   initial begin
      reset        = 1'b1;
      mem_clr      = 1'b1;
      cpu_mem_cmd  = 2'b00;
      cpu_mem_addr = 9'h000;
      cpu_wdata    = 16'h0000;
      b_req        = 1'b0;
      b_we         = 1'b0;
      b_addr       = 9'h000;
      b_wdata      = 16'h0000;
`ifdef MEM_ARB_MMIO_EN
      sw_in        = 8'h3C;
`endif
      tick();
      tick();
      reset   = 1'b0;
      mem_clr = 1'b0;
      settle();
      chk("rst_busy", b_busy, 0);
      chk("rst_ack", b_ack, 0);
      chk("rst_rdata", b_rdata, 0);
      chk("rst_starve", starve, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_addr", ram_addr, 0);
`ifdef MEM_ARB_MMIO_EN
      chk("rst_led", led_out, 0);
`endif

      // B write 0x1234 @0x05 on an idle bus
      tick();
      b_req = 1'b1; b_we = 1'b1; b_addr = 9'h005; b_wdata = 16'h1234;
      settle();
      chk("t1_req_busy", b_busy, 0);
      chk("t1_req_we", ram_we, 0);
      tick();
      b_req = 1'b0;
      settle();
      chk("t1_pend_busy", b_busy, 1);
      chk("t1_pend_we", ram_we, 1);
      chk("t1_pend_addr", ram_addr, 8'h05);
      chk("t1_pend_wdata", ram_wdata, 16'h1234);
      chk("t1_pend_ack", b_ack, 0);
      tick();
      settle();
      chk("t1_ack", b_ack, 1);
      chk("t1_ack_busy", b_busy, 0);
      chk("t1_ack_we", ram_we, 0);
      chk("t1_hold_addr", ram_addr, 8'h05);
      chk("t1_mem", mem[5], 16'h1234);
      tick();
      settle();
      chk("t1_ack_done", b_ack, 0);

      // cpu writes 0xBEEF @0x10, then MREADs it 6 cycles while B reads 0x05
      cpu_mem_cmd = 2'b10; cpu_mem_addr = 9'h010; cpu_wdata = 16'hBEEF;
      settle();
      chk("t2_cpuwr_we", ram_we, 1);
      chk("t2_cpuwr_addr", ram_addr, 8'h10);
      tick();
      cpu_mem_cmd = 2'b01;
      b_req = 1'b1; b_we = 1'b0; b_addr = 9'h005;
      settle();
      chk("t2_first_we", ram_we, 0);
      chk("t2_first_addr", ram_addr, 8'h10);
      tick();
      b_req = 1'b0;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         settle();
         if (ram_addr !== 8'h10 || ram_we !== 1'b0) bad++;
         chk("t2_cpu_rdata", cpu_rdata, 16'hBEEF);
         chk("t2_busy", b_busy, 1);
         tick();
      end
      cpu_mem_cmd = 2'b00;
      chk("t2_b_drives_while_cpu", bad, 0);
      settle();
      chk("t2_grant_addr", ram_addr, 8'h05);
      chk("t2_grant_we", ram_we, 0);
      tick();
      settle();
      chk("t2_rdwait_busy", b_busy, 1);
      chk("t2_rdwait_ack", b_ack, 0);
      tick();
      settle();
      chk("t2_ack", b_ack, 1);
      chk("t2_rdata", b_rdata, 16'h1234);
      tick();
      settle();
      chk("t2_ack_done", b_ack, 0);
      chk("t2_rdata_held", b_rdata, 16'h1234);

      // cpu busy 20 cycles with a B write pending
      cpu_mem_cmd = 2'b01; cpu_mem_addr = 9'h020;
      b_req = 1'b1; b_we = 1'b1; b_addr = 9'h030; b_wdata = 16'h5555;
      tick();
      b_req = 1'b0;
      for (int m = 1; m <= 19; m++) begin
         settle();
         chk($sformatf("t3_starve_c%0d", m), starve, (m >= 16));
         tick();
      end
      cpu_mem_cmd = 2'b00;
      settle();
      chk("t3_grant_starve", starve, 1);
      chk("t3_grant_we", ram_we, 1);
      chk("t3_grant_addr", ram_addr, 8'h30);
      tick();
      settle();
      chk("t3_ack", b_ack, 1);
      tick();
      settle();
      chk("t3_starve_clr", starve, 0);
      chk("t3_mem", mem[8'h30], 16'h5555);

      // reset while PEND, with a b_req in the reset cycle
      cpu_mem_cmd = 2'b01; cpu_mem_addr = 9'h020;
      b_req = 1'b1; b_we = 1'b1; b_addr = 9'h040; b_wdata = 16'h7777;
      tick();
      b_req = 1'b0;
      settle();
      chk("t4_busy", b_busy, 1);
      reset = 1'b1;
      b_req = 1'b1; b_addr = 9'h041; b_wdata = 16'h4141;
      tick();
      reset = 1'b0; b_req = 1'b0; cpu_mem_cmd = 2'b00;
      settle();
      chk("t4_busy_after", b_busy, 0);
      chk("t4_ack_after", b_ack, 0);
      chk("t4_rdata_cleared", b_rdata, 0);
      chk("t4_we_after", ram_we, 0);
      tick();
      settle();
      chk("t4_ack_later", b_ack, 0);
      chk("t4_busy_later", b_busy, 0);
      tick();
      settle();
      chk("t4_ack_later2", b_ack, 0);
      chk("t4_mem40", mem[8'h40], 16'h0000);
      chk("t4_mem41", mem[8'h41], 16'h0000);
      reset = 1'b1;
      b_req = 1'b1; b_we = 1'b1; b_addr = 9'h042; b_wdata = 16'h4242;
      tick();
      reset = 1'b0; b_req = 1'b0;
      settle();
      chk("t4_rst_beats_req", b_busy, 0);
      tick();
      settle();
      chk("t4_rst_beats_req_ack", b_ack, 0);
      chk("t4_mem42", mem[8'h42], 16'h0000);

      // cpu accesses to the I/O space
      cpu_mem_cmd = 2'b10; cpu_mem_addr = 9'h000; cpu_wdata = 16'hCAFE;
      tick();
      cpu_mem_addr = 9'h100; cpu_wdata = 16'h00A5;
      settle();
      chk("t5_io_we", ram_we, 0);
      chk("t5_io_addr", ram_addr, 8'h00);
      tick();
      cpu_mem_cmd = 2'b01; cpu_mem_addr = 9'h100;
      settle();
`ifdef MEM_ARB_MMIO_EN
      chk("t5_led", led_out, 8'hA5);
`endif
      chk("t5_cpu_io_rd", cpu_rdata, 16'h0000);
      tick();
      settle();
      chk("t5_cpu_io_rd2", cpu_rdata, 16'h0000);
      chk("t5_mem0", mem[0], 16'hCAFE);
      cpu_mem_addr = 9'h140;
      settle();
      chk("t5_sw_rd", cpu_rdata, SW_RD);
      tick();
      cpu_mem_cmd = 2'b00;

      // second request while busy is ignored
      cpu_mem_cmd = 2'b01; cpu_mem_addr = 9'h020;
      b_req = 1'b1; b_we = 1'b1; b_addr = 9'h006; b_wdata = 16'h6666;
      tick();
      b_addr = 9'h007; b_wdata = 16'h7070;
      tick();
      b_req = 1'b0; cpu_mem_cmd = 2'b00;
      settle();
      chk("t6_grant_addr", ram_addr, 8'h06);
      chk("t6_grant_wdata", ram_wdata, 16'h6666);
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         settle();
         if (b_ack === 1'b1) acks++;
      end
      chk("t6_ack_count", acks, 1);
      chk("t6_busy_end", b_busy, 0);
      chk("t6_mem6", mem[6], 16'h6666);
      chk("t6_mem7", mem[7], 16'h0000);

      // B read of RAM with the cpu using the bus during RDWAIT
      b_req = 1'b1; b_we = 1'b0; b_addr = 9'h010;
      tick();
      b_req = 1'b0;
      tick();
      cpu_mem_cmd = 2'b01; cpu_mem_addr = 9'h020;
      tick();
      cpu_mem_cmd = 2'b00;
      settle();
      chk("t7_ack", b_ack, 1);
      chk("t7_rdata", b_rdata, 16'hBEEF);

      // B write to 0x100 and B read of 0x140
      tick();
      b_req = 1'b1; b_we = 1'b1; b_addr = 9'h100; b_wdata = 16'h005A;
      tick();
      b_req = 1'b0;
      settle();
      chk("t7_iow_we", ram_we, 0);
      tick();
      settle();
      chk("t7_iow_ack", b_ack, 1);
`ifdef MEM_ARB_MMIO_EN
      chk("t7_led", led_out, 8'h5A);
`endif
      chk("t7_mem0", mem[0], 16'hCAFE);
      tick();
      b_req = 1'b1; b_we = 1'b0; b_addr = 9'h140;
      tick();
      b_req = 1'b0;
      tick();
      tick();
      settle();
      chk("t7_ior_ack", b_ack, 1);
      chk("t7_ior_rdata", b_rdata, SW_RD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
